// File: rtl/rob_multi.sv
// rob_multi: multi-way reorder buffer (dispatch, CDB complete, retire, lookup).
// Optional macro ROB_CDB_FWD_EN forwards same-cycle CDB results to lookups.
module rob_multi #(
  parameter int ROB_DEPTH = 16,
  parameter int DP_WIDTH  = 2,
  parameter int RT_WIDTH  = 2,
  parameter int CDB_WIDTH = 2,
  parameter int LK_PORTS  = 4,
  parameter int DATA_W    = 32,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DP_WIDTH-1:0]          dp_valid,
  input  logic [DP_WIDTH-1:0]          dp_has_dest,
  input  logic [DP_WIDTH*5-1:0]        dp_dest_reg,
  input  logic [DP_WIDTH*DATA_W-1:0]   dp_pc,
  output logic                         dp_ready,
  output logic [DP_WIDTH*TAG_W-1:0]    dp_tag,
  input  logic [CDB_WIDTH-1:0]         cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_WIDTH*DATA_W-1:0]  cdb_value,
  input  logic [CDB_WIDTH-1:0]         cdb_mispred,
  input  logic [CDB_WIDTH*DATA_W-1:0]  cdb_target,
  input  logic [LK_PORTS*TAG_W-1:0]    lk_tag,
  output logic [LK_PORTS-1:0]          lk_ready,
  output logic [LK_PORTS*DATA_W-1:0]   lk_value,
  output logic [RT_WIDTH-1:0]          rt_valid,
  output logic [RT_WIDTH-1:0]          rt_has_dest,
  output logic [RT_WIDTH*5-1:0]        rt_dest_reg,
  output logic [RT_WIDTH*DATA_W-1:0]   rt_value,
  output logic [RT_WIDTH*TAG_W-1:0]    rt_tag,
  output logic                         squash,
  output logic [DATA_W-1:0]            squash_pc,
  output logic                         rob_empty,
  output logic [TAG_W:0]               rob_count
);

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] cmpl_q, cmpl_d;
  logic [ROB_DEPTH-1:0] mis_q, mis_d;
  logic [ROB_DEPTH-1:0] hd_q, hd_d;
  logic [4:0]          dest_q  [ROB_DEPTH];
  logic [4:0]          dest_d  [ROB_DEPTH];
  logic [DATA_W-1:0]   value_q [ROB_DEPTH];
  logic [DATA_W-1:0]   value_d [ROB_DEPTH];
  logic [DATA_W-1:0]   pc_q    [ROB_DEPTH];
  logic [DATA_W-1:0]   pc_d    [ROB_DEPTH];
  logic [DATA_W-1:0]   tgt_q   [ROB_DEPTH];
  logic [DATA_W-1:0]   tgt_d   [ROB_DEPTH];
  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;
  logic [TAG_W:0]      rt_cnt, dp_cnt, free_slots;
  logic                cdb_dup;
  logic                pc_unused;

  assign rob_count  = count_q;
  assign rob_empty  = (count_q == '0);
  assign free_slots = (TAG_W+1)'(ROB_DEPTH) - count_q;
  assign dp_ready   = (free_slots >= (TAG_W+1)'(DP_WIDTH)) && !squash;

  always_comb begin
    dp_tag = '0;
    for (int i = 0; i < DP_WIDTH; i++)
      dp_tag[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
  end

  // Retire stops at the first incomplete entry or just after a mispredict.
  always_comb begin
    logic [TAG_W-1:0] idx;
    logic             stop;
    rt_valid    = '0;
    rt_has_dest = '0;
    rt_dest_reg = '0;
    rt_value    = '0;
    rt_tag      = '0;
    squash      = 1'b0;
    squash_pc   = '0;
    rt_cnt      = '0;
    stop        = 1'b0;
    for (int k = 0; k < RT_WIDTH; k++) begin
      idx = head_q + TAG_W'(k);
      if (!stop && valid_q[idx] && cmpl_q[idx]) begin
        rt_valid[k]                 = 1'b1;
        rt_has_dest[k]              = hd_q[idx];
        rt_dest_reg[k*5 +: 5]       = dest_q[idx];
        rt_value[k*DATA_W +: DATA_W] = value_q[idx];
        rt_tag[k*TAG_W +: TAG_W]    = idx;
        rt_cnt = rt_cnt + (TAG_W+1)'(1);
        if (mis_q[idx]) begin
          squash    = 1'b1;
          squash_pc = tgt_q[idx];
          stop      = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    logic [TAG_W-1:0] idx;
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    mis_d   = mis_q;
    hd_d    = hd_q;
    dest_d  = dest_q;
    value_d = value_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    dp_cnt  = '0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      idx = cdb_tag[c*TAG_W +: TAG_W];
      if (cdb_valid[c] && valid_q[idx]) begin
        cmpl_d[idx]  = 1'b1;
        mis_d[idx]   = cdb_mispred[c];
        value_d[idx] = cdb_value[c*DATA_W +: DATA_W];
        tgt_d[idx]   = cdb_target[c*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < RT_WIDTH; k++) begin
      idx = head_q + TAG_W'(k);
      if (rt_valid[k]) begin
        valid_d[idx] = 1'b0;
        cmpl_d[idx]  = 1'b0;
      end
    end
    for (int i = 0; i < DP_WIDTH; i++) begin
      idx = tail_q + TAG_W'(i);
      if (dp_ready && dp_valid[i]) begin
        valid_d[idx] = 1'b1;
        cmpl_d[idx]  = 1'b0;
        mis_d[idx]   = 1'b0;
        hd_d[idx]    = dp_has_dest[i];
        dest_d[idx]  = dp_dest_reg[i*5 +: 5];
        pc_d[idx]    = dp_pc[i*DATA_W +: DATA_W];
        dp_cnt = dp_cnt + (TAG_W+1)'(1);
      end
    end
    head_d  = head_q + rt_cnt[TAG_W-1:0];
    tail_d  = tail_q + dp_cnt[TAG_W-1:0];
    count_d = count_q + dp_cnt - rt_cnt;
    if (squash) begin
      valid_d = '0;
      cmpl_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    logic [TAG_W-1:0] t;
    lk_ready = '0;
    lk_value = '0;
    for (int p = 0; p < LK_PORTS; p++) begin
      t = lk_tag[p*TAG_W +: TAG_W];
      lk_ready[p] = valid_q[t] && cmpl_q[t];
      lk_value[p*DATA_W +: DATA_W] = value_q[t];
`ifdef ROB_CDB_FWD_EN
      for (int c = CDB_WIDTH-1; c >= 0; c--) begin
        if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
          lk_ready[p] = 1'b1;
          lk_value[p*DATA_W +: DATA_W] = cdb_value[c*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

  // PC is held per entry for trace/debug; nothing in this block reads it.
  always_comb begin
    pc_unused = 1'b0;
    for (int d = 0; d < ROB_DEPTH; d++)
      pc_unused = pc_unused ^ (^pc_q[d]);
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int i = 0; i < CDB_WIDTH; i++)
      for (int j = i+1; j < CDB_WIDTH; j++)
        if (cdb_valid[i] && cdb_valid[j] &&
            cdb_tag[i*TAG_W +: TAG_W] == cdb_tag[j*TAG_W +: TAG_W])
          cdb_dup = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!cdb_dup) else $error("rob_multi: duplicate CDB tag");
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      cmpl_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      cmpl_q  <= cmpl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is only meaningful while valid, so it needs no reset.
  always_ff @(posedge clock) begin
    mis_q   <= mis_d;
    hd_q    <= hd_d;
    dest_q  <= dest_d;
    value_q <= value_d;
    pc_q    <= pc_d;
    tgt_q   <= tgt_d;
  end

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed stimulus with a retire/squash scoreboard
// checked by an independent monitor process.
module tb_rob_multi;
  localparam int D  = 16;
  localparam int DW = 2;
  localparam int RW = 2;
  localparam int CW = 2;
  localparam int LP = 4;
  localparam int W  = 32;
  localparam int TW = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [DW-1:0]     dp_valid, dp_has_dest;
  logic [DW*5-1:0]   dp_dest_reg;
  logic [DW*W-1:0]   dp_pc;
  logic              dp_ready;
  logic [DW*TW-1:0]  dp_tag;
  logic [CW-1:0]     cdb_valid, cdb_mispred;
  logic [CW*TW-1:0]  cdb_tag;
  logic [CW*W-1:0]   cdb_value, cdb_target;
  logic [LP*TW-1:0]  lk_tag;
  logic [LP-1:0]     lk_ready;
  logic [LP*W-1:0]   lk_value;
  logic [RW-1:0]     rt_valid, rt_has_dest;
  logic [RW*5-1:0]   rt_dest_reg;
  logic [RW*W-1:0]   rt_value;
  logic [RW*TW-1:0]  rt_tag;
  logic              squash;
  logic [W-1:0]      squash_pc;
  logic              rob_empty;
  logic [TW:0]       rob_count;

  rob_multi dut (
    .clock(clock), .reset(reset),
    .dp_valid(dp_valid), .dp_has_dest(dp_has_dest),
    .dp_dest_reg(dp_dest_reg), .dp_pc(dp_pc),
    .dp_ready(dp_ready), .dp_tag(dp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_mispred(cdb_mispred),
    .cdb_target(cdb_target),
    .lk_tag(lk_tag), .lk_ready(lk_ready), .lk_value(lk_value),
    .rt_valid(rt_valid), .rt_has_dest(rt_has_dest),
    .rt_dest_reg(rt_dest_reg), .rt_value(rt_value),
    .rt_tag(rt_tag),
    .squash(squash), .squash_pc(squash_pc),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  tag;
    logic        hd;
    logic [4:0]  dest;
    logic [31:0] val;
  } rt_exp_t;

  rt_exp_t     rt_q[$];
  logic [31:0] sq_q[$];
  rt_exp_t     mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  int          tail_m = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  function automatic logic hd_of(input int t);
    return (t % 3) != 2;
  endfunction

  function automatic logic [4:0] dest_of(input int t);
    return 5'(t + 3);
  endfunction

  task automatic clear_inputs();
    dp_valid = '0; dp_has_dest = '0; dp_dest_reg = '0; dp_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    cdb_mispred = '0; cdb_target = '0; lk_tag = '0;
  endtask

  task automatic set_dp(input int n);
    dp_valid = '0; dp_has_dest = '0; dp_dest_reg = '0; dp_pc = '0;
    for (int i = 0; i < n; i++) begin
      int t;
      t = (tail_m + i) % D;
      dp_valid[i] = 1'b1;
      dp_has_dest[i] = hd_of(t);
      dp_dest_reg[i*5 +: 5] = dest_of(t);
      dp_pc[i*W +: W] = 32'h1000 + 32'(t * 4);
    end
  endtask

  task automatic set_cdb(input int ln, input int tag, input logic [31:0] v,
                         input logic mis, input logic [31:0] tgt);
    cdb_valid[ln] = 1'b1;
    cdb_tag[ln*TW +: TW] = 4'(tag);
    cdb_value[ln*W +: W] = v;
    cdb_mispred[ln] = mis;
    cdb_target[ln*W +: W] = tgt;
  endtask

  task automatic push_exp(input int tag, input logic [31:0] v);
    rt_q.push_back({4'(tag), hd_of(tag), dest_of(tag), v});
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every retiring lane and squash pulse must match the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (rt_valid != '0) chk("rt_contig", 64'(rt_valid[0]), 64'd1);
      for (int k = 0; k < RW; k++) begin
        if (rt_valid[k]) begin
          if (rt_q.size() == 0) begin
            chk("rt_unexpected", 64'(rt_tag[k*TW +: TW]), 64'hFF);
          end else begin
            mon_e = rt_q.pop_front();
            chk("rt_tag", 64'(rt_tag[k*TW +: TW]), 64'(mon_e.tag));
            chk("rt_value", 64'(rt_value[k*W +: W]), 64'(mon_e.val));
            chk("rt_has_dest", 64'(rt_has_dest[k]), 64'(mon_e.hd));
            if (mon_e.hd)
              chk("rt_dest", 64'(rt_dest_reg[k*5 +: 5]), 64'(mon_e.dest));
          end
        end
      end
      if (squash) begin
        if (sq_q.size() == 0) chk("squash_unexpected", 64'd1, 64'd0);
        else chk("squash_pc", 64'(squash_pc), 64'(sq_q.pop_front()));
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    at_neg();
    chk("rst_dp_ready", 64'(dp_ready), 64'd1);
    chk("rst_empty", 64'(rob_empty), 64'd1);
    chk("rst_count", 64'(rob_count), 64'd0);
    chk("rst_rt_valid", 64'(rt_valid), 64'd0);
    chk("rst_squash", 64'(squash), 64'd0);
    chk("rst_lk_ready", 64'(lk_ready), 64'd0);
    nxt();

    // Fill all 16 entries two per cycle
    for (int c = 0; c < 8; c++) begin
      set_dp(2);
      at_neg();
      chk("fill_ready", 64'(dp_ready), 64'd1);
      chk("fill_tag", 64'(dp_tag), 64'({4'(2*c+1), 4'(2*c)}));
      nxt();
      tail_m = (tail_m + 2) % D;
    end
    set_dp(2);
    at_neg();
    chk("full_count", 64'(rob_count), 64'd16);
    chk("full_ready", 64'(dp_ready), 64'd0);
    chk("full_empty", 64'(rob_empty), 64'd0);
    nxt();
    clear_inputs();
    at_neg();
    chk("full_hold", 64'(rob_count), 64'd16);
    chk("full_tail", 64'(dp_tag), 64'({4'd1, 4'd0}));
    nxt();

    // Out-of-order completion: tag 1 first, then tag 0
    set_cdb(0, 1, 32'h11, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    lk_tag[0 +: TW] = 4'd1;
    at_neg();
    chk("ooo_no_retire", 64'(rt_valid), 64'd0);
    chk("ooo_lk_ready1", 64'(lk_ready[0]), 64'd1);
    chk("ooo_lk_value1", 64'(lk_value[0 +: W]), 64'h11);
    chk("ooo_lk_ready0", 64'(lk_ready[1]), 64'd0);
    nxt();
    clear_inputs();
    push_exp(0, 32'h10);
    push_exp(1, 32'h11);
    set_cdb(0, 0, 32'h10, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    at_neg();
    chk("ooo_rt_valid", 64'(rt_valid), 64'd3);
    chk("ooo_count_pre", 64'(rob_count), 64'd16);
    nxt();
    at_neg();
    chk("ooo_count_post", 64'(rob_count), 64'd14);
    chk("ooo_ready_post", 64'(dp_ready), 64'd1);
    nxt();

    // Mispredict at head with younger entries complete
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    tail_m = 0;
    set_dp(2);
    nxt();
    tail_m = 2;
    set_dp(2);
    nxt();
    tail_m = 4;
    clear_inputs();
    set_cdb(0, 3, 32'h33, 1'b0, 32'h0);
    set_cdb(1, 2, 32'h22, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    set_cdb(0, 1, 32'h11, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    push_exp(0, 32'hDEAD);
    sq_q.push_back(32'h100);
    set_cdb(0, 0, 32'hDEAD, 1'b1, 32'h100);
    at_neg();
    chk("mis_blocked", 64'(rt_valid), 64'd0);
    nxt();
    clear_inputs();
    tail_m = 0;
    set_dp(2);
    at_neg();
    chk("mis_rt_valid", 64'(rt_valid), 64'd1);
    chk("mis_squash", 64'(squash), 64'd1);
    chk("mis_squash_pc", 64'(squash_pc), 64'h100);
    chk("mis_dp_ready", 64'(dp_ready), 64'd0);
    nxt();
    clear_inputs();
    at_neg();
    chk("flush_empty", 64'(rob_empty), 64'd1);
    chk("flush_count", 64'(rob_count), 64'd0);
    chk("flush_tail", 64'(dp_tag), 64'({4'd1, 4'd0}));
    chk("flush_rt_valid", 64'(rt_valid), 64'd0);
    chk("flush_squash", 64'(squash), 64'd0);
    nxt();

    // 20 dispatch/retire pairs: tags wrap 15 -> 0
    for (int i = 0; i <= 20; i++) begin
      clear_inputs();
      if (i < 20) set_dp(1);
      if (i > 0) begin
        set_cdb(0, (i-1) % D, 32'h500 + 32'(i-1), 1'b0, 32'h0);
        push_exp((i-1) % D, 32'h500 + 32'(i-1));
      end
      at_neg();
      if (i < 20) chk("wrap_tag", 64'(dp_tag[0 +: TW]), 64'(i % D));
      nxt();
      if (i < 20) tail_m = (tail_m + 1) % D;
    end
    clear_inputs();
    nxt();
    at_neg();
    chk("wrap_empty", 64'(rob_empty), 64'd1);
    nxt();

    // Lookup of a same-cycle completion, and a CDB hit on a free entry
    set_dp(2);
    nxt();
    tail_m = 6;
    clear_inputs();
    set_cdb(0, 5, 32'hABCD, 1'b0, 32'h0);
    lk_tag[0 +: TW] = 4'd5;
    at_neg();
`ifdef ROB_CDB_FWD_EN
    chk("fwd_lk_ready", 64'(lk_ready[0]), 64'd1);
    chk("fwd_lk_value", 64'(lk_value[0 +: W]), 64'hABCD);
`else
    chk("nofwd_lk_ready", 64'(lk_ready[0]), 64'd0);
`endif
    nxt();
    clear_inputs();
    lk_tag[0 +: TW] = 4'd5;
    at_neg();
    chk("lk_ready_next", 64'(lk_ready[0]), 64'd1);
    chk("lk_value_next", 64'(lk_value[0 +: W]), 64'hABCD);
    chk("lk_no_retire", 64'(rt_valid), 64'd0);
    nxt();
    clear_inputs();
    set_cdb(0, 9, 32'h99, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    lk_tag[2*TW +: TW] = 4'd9;
    at_neg();
    chk("lk_invalid_hit", 64'(lk_ready[2]), 64'd0);
    nxt();
    clear_inputs();
    push_exp(4, 32'h44);
    push_exp(5, 32'hABCD);
    set_cdb(1, 4, 32'h44, 1'b0, 32'h0);
    nxt();
    clear_inputs();
    at_neg();
    chk("lk_rt_count_pre", 64'(rob_count), 64'd2);
    nxt();
    at_neg();
    chk("lk_rt_count_post", 64'(rob_count), 64'd0);
    nxt();

    // Reset with 10 in flight and an active CDB broadcast
    for (int c = 0; c < 5; c++) begin
      set_dp(2);
      nxt();
      tail_m = (tail_m + 2) % D;
    end
    clear_inputs();
    at_neg();
    chk("mid_count10", 64'(rob_count), 64'd10);
    nxt();
    reset = 1'b1;
    set_cdb(0, 6, 32'h66, 1'b0, 32'h0);
    set_dp(2);
    nxt();
    reset = 1'b0;
    clear_inputs();
    tail_m = 0;
    lk_tag[0 +: TW] = 4'd6;
    at_neg();
    chk("mid_rst_count", 64'(rob_count), 64'd0);
    chk("mid_rst_rt_valid", 64'(rt_valid), 64'd0);
    chk("mid_rst_lk", 64'(lk_ready[0]), 64'd0);
    chk("mid_rst_tail", 64'(dp_tag), 64'({4'd1, 4'd0}));
    nxt();

    chk("rt_pending", 64'(rt_q.size()), 64'd0);
    chk("squash_pending", 64'(sq_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised, multi-way reorder buffer. Successor to the single-issue ROB.
- Per cycle it accepts up to DP_WIDTH in-order dispatches, absorbs up to CDB_WIDTH completions, retires up to RT_WIDTH completed head entries, and serves operand lookups for the RS.
- A mispredicted branch reaching the head retires and flushes every younger entry.
- Sits between dispatch/map table (allocate, lookup), CDB (complete) and the retire stage (register commit, fetch redirect).

Parameters:
- ROB_DEPTH, 16, entry count; power of 2, >= 4.
- DP_WIDTH, 2, dispatch lanes.
- RT_WIDTH, 2, retire lanes.
- CDB_WIDTH, 2, completion broadcast lanes.
- LK_PORTS, 4, operand lookup ports.
- DATA_W, 32, result/PC width.
- TAG_W, $clog2(ROB_DEPTH), tag width (derived, not overridable).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- dp_valid  in  DP_WIDTH  per-lane dispatch request; must be contiguous from lane 0
- dp_has_dest  in  DP_WIDTH  lane writes an architectural register
- dp_dest_reg  in  DP_WIDTH*5  architectural destination per lane
- dp_pc  in  DP_WIDTH*DATA_W  instruction PC per lane
- dp_ready  out  1  all DP_WIDTH lanes may dispatch this cycle
- dp_tag  out  DP_WIDTH*TAG_W  tag assigned to each lane (tail+i)
- cdb_valid  in  CDB_WIDTH  completion valid per lane
- cdb_tag  in  CDB_WIDTH*TAG_W  completing tag
- cdb_value  in  CDB_WIDTH*DATA_W  result
- cdb_mispred  in  CDB_WIDTH  branch mispredicted
- cdb_target  in  CDB_WIDTH*DATA_W  correct branch target
- lk_tag  in  LK_PORTS*TAG_W  operand tag lookup
- lk_ready  out  LK_PORTS  looked-up entry complete
- lk_value  out  LK_PORTS*DATA_W  looked-up entry value
- rt_valid  out  RT_WIDTH  retiring lane valid; contiguous from lane 0
- rt_has_dest  out  RT_WIDTH  retiring lane writes a register
- rt_dest_reg  out  RT_WIDTH*5  retiring destination
- rt_value  out  RT_WIDTH*DATA_W  retiring value
- rt_tag  out  RT_WIDTH*TAG_W  retiring tag (map-table clear)
- squash  out  1  flush pulse
- squash_pc  out  DATA_W  redirect target
- rob_empty  out  1  count == 0
- rob_count  out  TAG_W+1  occupied entries

Behaviour:
- Storage per entry: valid, complete, mispred, has_dest, dest_reg, value, pc, target.
- head/tail are TAG_W bits and wrap naturally modulo ROB_DEPTH. A separate count register disambiguates full from empty; there is no sentinel slot.
- Reset (synchronous): head=tail=0, count=0, all valid/complete cleared.
  - Outputs after reset: dp_ready=1, rob_empty=1, rob_count=0, rt_valid=0, squash=0, lk_ready=0.
- Dispatch:
  - dp_ready = (ROB_DEPTH - count >= DP_WIDTH) && !squash, computed from registered count only.
  - When dp_ready, each lane with dp_valid[i] writes entry tail+i with valid=1, complete=0, mispred=0.
  - tail advances by popcount(dp_valid).
  - dp_valid while !dp_ready is ignored.
- Completion:
  - On each edge, each cdb_valid lane whose tag hits a valid entry sets complete=1 and writes value, mispred and target.
  - A hit on an invalid entry is ignored.
  - Two lanes carrying the same tag is illegal; the verification assertion flags it.
- Retire (combinational outputs from current state):
  - Lane k is valid iff entries head..head+k are all valid and complete.
  - No lane beyond the first mispredicted entry retires.
  - Lane k=0 may retire the mispredicted entry itself.
  - On the edge, retired entries are cleared, head advances by the retired count, and count = count + dispatched - retired.
- Squash:
  - squash=1 in the same cycle a retiring lane carries mispred.
  - squash_pc = that entry's target.
  - On that edge, all entries are invalidated and head=tail=0, count=0.
  - Dispatch and CDB writes in that cycle are discarded.
- Lookup:
  - Combinational from registered state.
  - lk_ready = valid && complete of entry lk_tag; lk_value = that entry's value.
- Full boundary: count==ROB_DEPTH gives dp_ready=0. A retire in the same cycle frees slots only from the next cycle.
- Wrap: tail+i and head+k wrap modulo ROB_DEPTH. Tags are reused only after retire.
- Reset mid-operation overrides all activity in that cycle.

Optional Feature:
- Macro: ROB_CDB_FWD_EN.
- Defined: lookup ports forward same-cycle CDB results. If any cdb_valid lane's tag equals lk_tag, then lk_ready=1 and lk_value comes from that CDB lane; the lowest-index lane wins.
- Undefined: lookups reflect registered state only, and a same-cycle completion becomes visible the next cycle.

Test Plan:
- Reset, then dispatch 2 lanes per cycle for 8 cycles with no CDB activity -> tags 0..15 assigned, rob_count=16, dp_ready=0 in cycle 9.
- Complete tags 1 then 0 (out of order) -> no retire after tag 1 alone; after tag 0, rt_valid=2'b11 with rt_tag={1,0}; rob_count drops by 2 the next cycle.
- Tag 0 complete with mispred, cdb_target=0x100, tags 1-3 complete -> rt_valid=2'b01, squash=1, squash_pc=0x100; next cycle rob_empty=1 and head=tail=0.
- Run 20 dispatch/retire pairs through a 16-entry ROB -> tail wraps 15->0 correctly and rt_value matches the per-tag CDB values in order.
- With ROB_CDB_FWD_EN defined: CDB on tag 5 with value 0xABCD and lk_tag=5 in the same cycle -> lk_ready=1 and lk_value=0xABCD in that cycle. Without the macro -> lk_ready=0 in that cycle, 1 in the next.
- Assert reset while 10 entries are in flight and a CDB broadcast is active -> next cycle rob_count=0, rt_valid=0, and the CDB write is discarded.
